// File: rtl/regfile_burst_reader_pkg.sv
// Shared constants for the regfile burst reader: controller state encoding
// and default bank geometry.
package regfile_burst_reader_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREG  = 4;
  localparam int DEF_AW    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_burst_reader_read_mux.sv
// NREG:1 word selector over the flattened bank bus, built as a log2(NREG)-deep
// tree of 2:1 muxes; level d merges pairs using select bit d-1.
module regfile_read_mux
  import regfile_burst_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic [NREG*WIDTH-1:0] bank,
  input  logic [AW-1:0]         sel,
  output logic [WIDTH-1:0]      word
);

  for (genvar d = 0; d <= AW; d++) begin : lv
    logic [(NREG>>d)-1:0][WIDTH-1:0] n;
    if (d == 0) begin : leaf
      assign n = bank;
    end else begin : merge
      // LSB picks within adjacent pairs first, so the tree follows address order
      for (genvar j = 0; j < (NREG >> d); j++) begin : m2
        assign n[j] = sel[d-1] ? lv[d-1].n[2*j+1] : lv[d-1].n[2*j];
      end
    end
  end

  assign word = lv[AW].n[0];

endmodule

// File: rtl/regfile_burst_reader.sv
// Burst reader for a regfile bank: streams LEN+1 consecutive words from ADDR,
// wrapping mod NREG. Optional macro READ_PARITY_EN adds registered parity QPAR.
module regfile_burst_reader
  import regfile_burst_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic [AW-1:0]         ADDR,
  input  logic [AW-1:0]         LEN,
  input  logic [NREG*WIDTH-1:0] BANK,
  output logic                  RDY,
  output logic [WIDTH-1:0]      Q,
  output logic                  VALID,
  output logic                  LAST
`ifdef READ_PARITY_EN
  ,
  output logic                  QPAR
`endif
);

  state_t           state, state_n;
  logic [AW-1:0]    ptr, ptr_n, rem, rem_n, sel;
  logic [WIDTH-1:0] word, q_n;
  logic             valid_n, last_n;

  assign RDY = (state == ST_IDLE);
  // Idle issues straight from the request address; bursts continue from ptr
  assign sel = RDY ? ADDR : ptr;

  regfile_read_mux #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_mux (
    .bank (BANK),
    .sel  (sel),
    .word (word)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    rem_n   = rem;
    q_n     = Q;
    valid_n = 1'b0;
    last_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (REQ) begin
          q_n     = word;
          valid_n = 1'b1;
          last_n  = (LEN == '0);
          if (LEN != '0) begin
            ptr_n   = ADDR + AW'(1);
            rem_n   = LEN - AW'(1);
            state_n = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        q_n     = word;
        valid_n = 1'b1;
        last_n  = (rem == '0);
        ptr_n   = ptr + AW'(1);
        rem_n   = rem - AW'(1);
        if (rem == '0) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      ptr   <= '0;
      rem   <= '0;
      Q     <= '0;
      VALID <= 1'b0;
      LAST  <= 1'b0;
`ifdef READ_PARITY_EN
      QPAR  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      rem   <= rem_n;
      Q     <= q_n;
      VALID <= valid_n;
      LAST  <= last_n;
`ifdef READ_PARITY_EN
      // q_n equals Q when nothing is issued, so parity tracks Q exactly
      QPAR  <= ^q_n;
`endif
    end
  end

endmodule
